// File: rtl/pmcc_fetch_pkg.sv
// pmcc_fetch_pkg: shared types and helpers for the PMC controller fetch stage.
//   fetch_state_t : fetch FSM state encoding
//   PMCC_PC_W     : code RAM word-address width (1024 x 32 bit)
//   PMCC_NOP      : bubble instruction presented while nothing is valid
//   pc_word_ok()  : redirect target legality check, also used by decode
package pmcc_fetch_pkg;

    localparam int unsigned PMCC_PC_W   = 10;
    localparam int unsigned PMCC_XLEN   = 32;
    localparam logic [31:0] PMCC_NOP    = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH_IDLE   = 2'd0,
        FETCH_RUN    = 2'd1,
        FETCH_HALTED = 2'd2,
        FETCH_FAULT  = 2'd3
    } fetch_state_t;

    // Instruction/PC pair handed to decode.
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_result_t;

    // A target is legal when word aligned and inside the code RAM.
    function automatic logic pc_word_ok(input logic [31:0] target);
        return (target[1:0] == 2'b00) && (target[31:PMCC_PC_W+2] == '0);
    endfunction

endpackage

// File: rtl/pmcc_fetch_perf.sv
// pmcc_fetch_perf: fetch/stall event counters for the fetch stage.
//   clk, rst_n     : clock, async active-low reset
//   clr            : synchronous clear of both counters (wins over increment)
//   inc_fetch      : count one delivered instruction this cycle
//   inc_stall      : count one stalled valid cycle
//   fetch_cnt      : saturating delivered-instruction count
//   stall_cnt      : saturating stalled-cycle count
module pmcc_fetch_perf
    import pmcc_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        inc_fetch,
    input  logic        inc_stall,
    output logic [31:0] fetch_cnt,
    output logic [31:0] stall_cnt
);

    localparam int unsigned CNT_W = PMCC_XLEN;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Counters stick at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
        end else if (clr) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (inc_fetch && (fetch_cnt != CNT_MAX)) begin
                fetch_cnt <= fetch_cnt + CNT_W'(1);
            end
            if (inc_stall && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/pmcc_fetch.sv
// pmcc_fetch: instruction fetch stage of the PMC controller.
// Drives the code RAM word address (pc_if, combinational; RAM registers it)
// and pairs the word returned one cycle later with its PC for decode.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   start_i, boot_addr_i: begin fetching at boot_addr_i from IDLE/HALTED/FAULT
//   stall_i             : decode cannot accept; hold current instruction
//   redirect_i, redirect_target_i : taken branch/jump (byte address)
//   halt_i              : stop fetching
//   instr_i             : code RAM read data for the previous pc_if
//   pc_if               : code RAM word address
//   instr_id_o, pc_id_o, instr_valid_id_o : result to decode
//   busy_o              : fetch is running
//   fault_o             : sticky bad redirect target, cleared by start_i
// Build option PMCC_FETCH_PERF_EN adds perf_clr_i, fetch_cnt_o, stall_cnt_o.
module pmcc_fetch
    import pmcc_fetch_pkg::*;
#(
    parameter int unsigned PC_W      = PMCC_PC_W,
    parameter logic [31:0] NOP_INSTR = PMCC_NOP
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [PC_W-1:0] boot_addr_i,
    input  logic            stall_i,
    input  logic            redirect_i,
    input  logic [31:0]     redirect_target_i,
    input  logic            halt_i,
    input  logic [31:0]     instr_i,
    output logic [PC_W-1:0] pc_if,
    output logic [31:0]     instr_id_o,
    output logic [31:0]     pc_id_o,
    output logic            instr_valid_id_o,
    output logic            busy_o,
    output logic            fault_o
`ifdef PMCC_FETCH_PERF_EN
    ,
    input  logic            perf_clr_i,
    output logic [31:0]     fetch_cnt_o,
    output logic [31:0]     stall_cnt_o
`endif
);

    fetch_state_t    state_q;
    logic [PC_W-1:0] pc_id_q;
    logic            valid_q;
    logic            fault_q;
    logic            target_ok_c;
    fetch_result_t   result_c;

    assign target_ok_c = pc_word_ok(redirect_target_i);

    // Next fetch address. The RAM re-reads pc_id_q whenever fetch holds,
    // so instr_i stays stable for a stalled or stopped instruction.
    always_comb begin
        pc_if = pc_id_q;
        if (state_q == FETCH_RUN) begin
            if (!halt_i) begin
                if (redirect_i) begin
                    if (target_ok_c) begin
                        pc_if = redirect_target_i[PC_W+1:2];
                    end
                end else if (valid_q && !stall_i) begin
                    pc_if = pc_id_q + PC_W'(1);
                end
            end
        end else if (start_i) begin
            pc_if = boot_addr_i;
        end
    end

    // FSM and registered decode-side state. pc_id_q always follows the
    // address the RAM just latched, so it names the word on instr_i.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH_IDLE;
            pc_id_q <= '0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            pc_id_q <= pc_if;
            case (state_q)
                FETCH_RUN: begin
                    if (halt_i) begin
                        state_q <= FETCH_HALTED;
                        valid_q <= 1'b0;
                    end else if (redirect_i && !target_ok_c) begin
                        state_q <= FETCH_FAULT;
                        fault_q <= 1'b1;
                        valid_q <= 1'b0;
                    end else begin
                        // redirect, stall hold and sequential fetch all
                        // present a word next cycle
                        valid_q <= 1'b1;
                    end
                end
                default: begin
                    if (start_i) begin
                        state_q <= FETCH_RUN;
                        valid_q <= 1'b1;
                        fault_q <= 1'b0;
                    end else begin
                        valid_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Result pairing for decode.
    always_comb begin
        result_c.valid = valid_q;
        result_c.pc    = 32'({pc_id_q, 2'b00});
        result_c.instr = valid_q ? instr_i : NOP_INSTR;
    end

    assign instr_id_o       = result_c.instr;
    assign pc_id_o          = result_c.pc;
    assign instr_valid_id_o = result_c.valid;
    assign busy_o           = (state_q == FETCH_RUN);
    assign fault_o          = fault_q;

`ifdef PMCC_FETCH_PERF_EN
    pmcc_fetch_perf u_perf (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (perf_clr_i),
        .inc_fetch (valid_q && !stall_i),
        .inc_stall (valid_q && stall_i),
        .fetch_cnt (fetch_cnt_o),
        .stall_cnt (stall_cnt_o)
    );
`endif

endmodule

// File: tb/tb_pmcc_fetch.sv
// tb_pmcc_fetch: self-checking bench for pmcc_fetch with a code RAM model
// and a behavioural fetch reference. Directed scenarios then random traffic.
// Build with PMCC_FETCH_PERF_EN defined to cover the counters as well.
module tb_pmcc_fetch;

    localparam int unsigned PC_W  = 10;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_STOP = 2;

    logic            clk;
    logic            rst_n;
    logic            start_i;
    logic [PC_W-1:0] boot_addr_i;
    logic            stall_i;
    logic            redirect_i;
    logic [31:0]     redirect_target_i;
    logic            halt_i;
    logic [31:0]     instr_i;
    logic [PC_W-1:0] pc_if;
    logic [31:0]     instr_id_o;
    logic [31:0]     pc_id_o;
    logic            instr_valid_id_o;
    logic            busy_o;
    logic            fault_o;
    logic            perf_clr_i;
`ifdef PMCC_FETCH_PERF_EN
    logic [31:0]     fetch_cnt_o;
    logic [31:0]     stall_cnt_o;
`endif

    pmcc_fetch dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start_i           (start_i),
        .boot_addr_i       (boot_addr_i),
        .stall_i           (stall_i),
        .redirect_i        (redirect_i),
        .redirect_target_i (redirect_target_i),
        .halt_i            (halt_i),
        .instr_i           (instr_i),
        .pc_if             (pc_if),
        .instr_id_o        (instr_id_o),
        .pc_id_o           (pc_id_o),
        .instr_valid_id_o  (instr_valid_id_o),
        .busy_o            (busy_o),
        .fault_o           (fault_o)
`ifdef PMCC_FETCH_PERF_EN
        ,
        .perf_clr_i        (perf_clr_i),
        .fetch_cnt_o       (fetch_cnt_o),
        .stall_cnt_o       (stall_cnt_o)
`endif
    );

    logic [31:0] mem [1024];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // code RAM: one-cycle synchronous read
    always @(posedge clk) instr_i <= mem[pc_if];

    int n_checks = 0;
    int n_errors = 0;

    // reference model
    int          m_state;
    int          m_pc;
    bit          m_valid;
    bit          m_fault;
    longint      m_fcnt;
    longint      m_scnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = M_IDLE;
        m_pc    = 0;
        m_valid = 0;
        m_fault = 0;
        m_fcnt  = 0;
        m_scnt  = 0;
    endtask

    task automatic check_outputs();
        check("valid", 32'(instr_valid_id_o), 32'(m_valid));
        check("pc_id", pc_id_o, 32'(m_pc * 4));
        check("instr_id", instr_id_o, m_valid ? mem[m_pc] : NOP);
        check("busy", 32'(busy_o), 32'(m_state == M_RUN));
        check("fault", 32'(fault_o), 32'(m_fault));
`ifdef PMCC_FETCH_PERF_EN
        check("fetch_cnt", fetch_cnt_o, 32'(m_fcnt));
        check("stall_cnt", stall_cnt_o, 32'(m_scnt));
`endif
    endtask

    // One clock cycle: drive, check against the model, advance the model.
    task automatic step(input bit st, input int boot, input bit stl, input bit rd,
                        input logic [31:0] tgt, input bit hl, input bit clr);
        int  exp_if;
        bit  ok;
        @(negedge clk);
        start_i           = st;
        boot_addr_i       = PC_W'(boot);
        stall_i           = stl;
        redirect_i        = rd;
        redirect_target_i = tgt;
        halt_i            = hl;
        perf_clr_i        = clr;
        #1;
        check_outputs();
        ok = (tgt % 4 == 0) && (tgt < 32'd4096);
        if (m_state != M_RUN)       exp_if = st ? boot : m_pc;
        else if (hl)                exp_if = m_pc;
        else if (rd && !ok)         exp_if = m_pc;
        else if (rd)                exp_if = int'(tgt / 4);
        else if (stl && m_valid)    exp_if = m_pc;
        else if (m_valid)           exp_if = (m_pc + 1) % 1024;
        else                        exp_if = m_pc;
        check("pc_if", 32'(pc_if), 32'(exp_if));
        if (clr) begin
            m_fcnt = 0;
            m_scnt = 0;
        end else if (m_valid) begin
            if (stl) m_scnt = (m_scnt < 64'hFFFF_FFFF) ? m_scnt + 1 : m_scnt;
            else     m_fcnt = (m_fcnt < 64'hFFFF_FFFF) ? m_fcnt + 1 : m_fcnt;
        end
        if (m_state != M_RUN) begin
            if (st) begin
                m_state = M_RUN;
                m_valid = 1;
                m_fault = 0;
            end else begin
                m_valid = 0;
            end
        end else if (hl) begin
            m_state = M_STOP;
            m_valid = 0;
        end else if (rd && !ok) begin
            m_state = M_STOP;
            m_fault = 1;
            m_valid = 0;
        end else begin
            m_valid = 1;
        end
        m_pc = exp_if;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    // Asynchronous reset asserted mid-cycle, released a cycle later.
    task automatic apply_reset();
        @(negedge clk);
        start_i = 0; stall_i = 0; redirect_i = 0; halt_i = 0; perf_clr_i = 0;
        boot_addr_i = '0; redirect_target_i = '0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_pc_if", 32'(pc_if), 32'h0);
        check("rst_instr", instr_id_o, NOP);
        check("rst_pc_id", pc_id_o, 32'h0);
        check("rst_valid", 32'(instr_valid_id_o), 32'h0);
        check("rst_busy", 32'(busy_o), 32'h0);
        check("rst_fault", 32'(fault_o), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic after_edge_check(input string tag, input logic [31:0] exp);
        @(posedge clk);
        #1;
        check(tag, pc_id_o, exp);
    endtask

    initial begin
        logic [31:0] tgt;
        int          r;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        rst_n = 1'b0;
        model_reset();
        apply_reset();
        idle(2);

        // boot at 0x010 and fetch sequentially
        step(1, 'h010, 0, 0, 0, 0, 0);
        after_edge_check("boot_pc_id", 32'h40);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        // three stall cycles holding pc 0x012
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 0, 0);
        check("stall_pc_id", pc_id_o, 32'h48);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        // start while running is ignored
        step(1, 'h200, 0, 0, 0, 0, 0);
        // redirect, then redirect together with stall
        step(0, 0, 0, 1, 32'h0000_0100, 0, 0);
        after_edge_check("redir_pc_id", 32'h100);
        step(0, 0, 1, 1, 32'h0000_0200, 0, 0);
        after_edge_check("redir_stall_pc_id", 32'h200);
        step(0, 0, 0, 0, 0, 0, 0);
        // misaligned target faults, start clears it
        step(0, 0, 0, 1, 32'h0000_0102, 0, 0);
        idle(2);
        step(1, 'h020, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        // out-of-range target faults
        step(0, 0, 0, 1, 32'h0000_1000, 0, 0);
        idle(1);
        // wrap 0x3FF -> 0x000, then halt
        step(1, 'h3FE, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        after_edge_check("wrap_pc_id", 32'h0);
        step(0, 0, 0, 0, 0, 1, 0);
        idle(2);
        // reset in the middle of a run
        step(1, 'h155, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        apply_reset();

        // counters: 5 valid cycles with 2 stalls, then clear
        step(0, 0, 0, 0, 0, 0, 1);
        step(1, 'h080, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0);
`ifdef PMCC_FETCH_PERF_EN
        @(posedge clk);
        #1;
        check("perf_fetch_3", fetch_cnt_o, 32'd3);
        check("perf_stall_2", stall_cnt_o, 32'd2);
`endif
        step(0, 0, 0, 0, 0, 0, 1);
        idle(1);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 99));
            if ($urandom_range(0, 3) == 0)
                tgt = $urandom;
            else
                tgt = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
            step(r < 4, int'($urandom_range(0, 1023)), $urandom_range(0, 3) == 0,
                 $urandom_range(0, 9) == 0, tgt, r >= 98, $urandom_range(0, 49) == 0);
            if ($urandom_range(0, 499) == 0) apply_reset();
        end
        idle(1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
